// File: rtl/centipede_pkg.sv
// Shared definitions for the centipede trackball emulation path.
package centipede_pkg;

    // Per-axis step sequencer states.
    typedef enum logic [1:0] {
        AXIS_IDLE  = 2'd0,
        AXIS_SETUP = 2'd1,
        AXIS_HIGH  = 2'd2,
        AXIS_LOW   = 2'd3
    } axis_state_e;

    // Bit positions inside the 8-bit trakball bus.
    localparam logic [2:0] TB_HCLK = 3'd0;
    localparam logic [2:0] TB_HDIR = 3'd1;
    localparam logic [2:0] TB_VCLK = 3'd2;
    localparam logic [2:0] TB_VDIR = 3'd3;

endpackage

// File: rtl/trakball_axis_pulser.sv
// One trackball axis: signed pending-motion accumulator plus a step sequencer
// that turns each unit of motion into a dir-setup / clk-high / clk-low step.
module trakball_axis_pulser
    import centipede_pkg::*;
#(
    parameter int unsigned SETUP_W = 16,
    parameter int unsigned PULSE_W = 64,
    parameter int unsigned ACC_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [ACC_W-1:0] delta,
    output logic                    step_clk,
    output logic                    step_dir,
    output logic                    busy_c
);

    localparam int unsigned CNT_MAX = (SETUP_W > PULSE_W) ? SETUP_W : PULSE_W;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned SUM_W   = ACC_W + 2;

    localparam logic [CNT_W-1:0]        SETUP_LOAD = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0]        PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic signed [SUM_W-1:0] ACC_MAX    = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN    = -ACC_MAX;

    axis_state_e             state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic                    dir_next;
    logic                    clk_next;
    logic signed [1:0]       consume_c;
    logic signed [SUM_W-1:0] sum_c;

    // State, counter, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= AXIS_IDLE;
            cnt      <= '0;
            acc      <= '0;
            step_dir <= 1'b0;
            step_clk <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            acc      <= acc_next;
            step_dir <= dir_next;
            step_clk <= clk_next;
        end
    end

    // Step sequencing, one unit consumed on entry to HIGH, saturating accumulate.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = step_dir;
        consume_c  = 2'sd0;
        unique case (state)
            AXIS_IDLE: begin
                if (acc != '0) begin
                    state_next = AXIS_SETUP;
                    dir_next   = ~acc[ACC_W-1];
                    cnt_next   = SETUP_LOAD;
                end
            end
            AXIS_SETUP: begin
                if (cnt == '0) begin
                    state_next = AXIS_HIGH;
                    cnt_next   = PULSE_LOAD;
                    consume_c  = step_dir ? 2'sd1 : -2'sd1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            AXIS_HIGH: begin
                if (cnt == '0) begin
                    state_next = AXIS_LOW;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            AXIS_LOW: begin
                if (cnt == '0) begin
                    if (acc != '0) begin
                        state_next = AXIS_SETUP;
                        dir_next   = ~acc[ACC_W-1];
                        cnt_next   = SETUP_LOAD;
                    end else begin
                        state_next = AXIS_IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = AXIS_IDLE;
        endcase

        sum_c = SUM_W'(acc) + SUM_W'(delta) - SUM_W'(consume_c);
        if (sum_c > ACC_MAX) begin
            acc_next = ACC_W'(ACC_MAX);
        end else if (sum_c < ACC_MIN) begin
            acc_next = ACC_W'(ACC_MIN);
        end else begin
            acc_next = ACC_W'(sum_c);
        end
    end

    // Next-cycle output values derived from the next state.
    always_comb begin
        clk_next = (state_next == AXIS_HIGH);
        busy_c   = (state_next != AXIS_IDLE) || (acc_next != '0);
    end

endmodule

// File: rtl/trakball_quad_encoder.sv
// Trackball emulator: accepts signed X/Y motion deltas and drives the
// centipede core's trakball bus with per-axis direction/clock step trains.
module trakball_quad_encoder
    import centipede_pkg::*;
#(
    parameter int unsigned SETUP_W = 16,
    parameter int unsigned PULSE_W = 64,
    parameter int unsigned ACC_W   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] delta_x_i,
    input  logic [7:0] delta_y_i,
    input  logic       delta_valid_i,
    output logic       delta_ready_o,
    output logic [7:0] trakball_o,
    output logic       busy_o
);

    logic                    accept_c;
    logic signed [ACC_W-1:0] dx_c, dy_c;
    logic                    x_clk, x_dir, x_busy_c;
    logic                    y_clk, y_dir, y_busy_c;

    // Accepted deltas sign-extended to accumulator width; zero when not accepted.
    always_comb begin
        accept_c = delta_valid_i & delta_ready_o;
        dx_c     = accept_c ? ACC_W'(signed'(delta_x_i)) : '0;
        dy_c     = accept_c ? ACC_W'(signed'(delta_y_i)) : '0;
    end

    trakball_axis_pulser #(
        .SETUP_W (SETUP_W),
        .PULSE_W (PULSE_W),
        .ACC_W   (ACC_W)
    ) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .delta    (dx_c),
        .step_clk (x_clk),
        .step_dir (x_dir),
        .busy_c   (x_busy_c)
    );

    trakball_axis_pulser #(
        .SETUP_W (SETUP_W),
        .PULSE_W (PULSE_W),
        .ACC_W   (ACC_W)
    ) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .delta    (dy_c),
        .step_clk (y_clk),
        .step_dir (y_dir),
        .busy_c   (y_busy_c)
    );

    // Ready and busy flags; ready comes up the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            delta_ready_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            delta_ready_o <= 1'b1;
            busy_o        <= x_busy_c | y_busy_c;
        end
    end

    // Pack the registered axis bits onto the trakball bus.
    always_comb begin
        trakball_o          = '0;
        trakball_o[TB_HCLK] = x_clk;
        trakball_o[TB_HDIR] = x_dir;
        trakball_o[TB_VCLK] = y_clk;
        trakball_o[TB_VDIR] = y_dir;
    end

endmodule

// File: tb/tb_trakball_quad_encoder.sv
// Randomized and directed bench for trakball_quad_encoder against a
// step-phase reference model of the trackball emission rules.
module tb_trakball_quad_encoder;

    localparam int SW   = 2;
    localparam int PW   = 4;
    localparam int AW   = 10;
    localparam int STEP = SW + 2 * PW;
    localparam int AMAX = (1 << (AW - 1)) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] delta_x_i, delta_y_i;
    logic       delta_valid_i;
    logic       delta_ready_o;
    logic [7:0] trakball_o;
    logic       busy_o;

    trakball_quad_encoder #(
        .SETUP_W (SW),
        .PULSE_W (PW),
        .ACC_W   (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .delta_x_i     (delta_x_i),
        .delta_y_i     (delta_y_i),
        .delta_valid_i (delta_valid_i),
        .delta_ready_o (delta_ready_o),
        .trakball_o    (trakball_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model: pending motion, step phase, dir, clk per axis
    int m_acc [2];
    bit m_act [2];
    int m_ph  [2];
    bit m_dir [2];
    bit m_clk [2];
    bit m_ready;
    int m_rises [2];

    // observed DUT behaviour
    bit d_prev_clk [2];
    int d_rises    [2];
    int d_up_rises [2];
    int d_first    [2];
    int d_last     [2];
    bit d_prev_busy;
    int busy_fall;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > AMAX) return AMAX;
        if (v < -AMAX) return -AMAX;
        return v;
    endfunction

    function automatic bit m_busy();
        return (m_acc[0] != 0) || (m_acc[1] != 0) || m_act[0] || m_act[1];
    endfunction

    task automatic model_edge(input bit v, input logic signed [7:0] dx,
                              input logic signed [7:0] dy, input bit rst);
        int add [2];
        int consume;
        bit new_clk;
        if (rst) begin
            for (int a = 0; a < 2; a++) begin
                m_acc[a] = 0; m_act[a] = 0; m_ph[a] = 0; m_dir[a] = 0; m_clk[a] = 0;
            end
            m_ready = 0;
            return;
        end
        add[0] = (v && m_ready) ? int'(dx) : 0;
        add[1] = (v && m_ready) ? int'(dy) : 0;
        for (int a = 0; a < 2; a++) begin
            consume = 0;
            if (!m_act[a]) begin
                if (m_acc[a] != 0) begin
                    m_act[a] = 1; m_ph[a] = 0; m_dir[a] = (m_acc[a] > 0);
                end
            end else if (m_ph[a] == STEP - 1) begin
                if (m_acc[a] != 0) begin
                    m_ph[a] = 0; m_dir[a] = (m_acc[a] > 0);
                end else begin
                    m_act[a] = 0;
                end
            end else begin
                m_ph[a]++;
                if (m_ph[a] == SW) consume = m_dir[a] ? 1 : -1;
            end
            m_acc[a] = sat(m_acc[a] + add[a] - consume);
            new_clk = m_act[a] && (m_ph[a] >= SW) && (m_ph[a] < SW + PW);
            if (new_clk && !m_clk[a]) m_rises[a]++;
            m_clk[a] = new_clk;
        end
        m_ready = 1;
    endtask

    task automatic clear_counts();
        for (int a = 0; a < 2; a++) begin
            m_rises[a] = 0; d_rises[a] = 0; d_up_rises[a] = 0;
            d_first[a] = -1; d_last[a] = -1;
        end
        busy_fall = -1;
    endtask

    // one clock: drive, let the edge happen, advance model, compare
    task automatic tick(input bit v, input logic signed [7:0] dx,
                        input logic signed [7:0] dy, input bit rst);
        bit c [2];
        bit d [2];
        delta_valid_i = v;
        delta_x_i     = dx;
        delta_y_i     = dy;
        reset         = rst;
        @(posedge clk);
        cyc++;
        model_edge(v, dx, dy, rst);
        #1;
        check("trakball", int'(trakball_o),
              int'({4'b0, m_dir[1], m_clk[1], m_dir[0], m_clk[0]}));
        check("busy", int'(busy_o), int'(m_busy()));
        check("ready", int'(delta_ready_o), int'(m_ready));
        c[0] = trakball_o[0]; d[0] = trakball_o[1];
        c[1] = trakball_o[2]; d[1] = trakball_o[3];
        for (int a = 0; a < 2; a++) begin
            if (c[a] && !d_prev_clk[a]) begin
                d_rises[a]++;
                if (d[a]) d_up_rises[a]++;
                if (d_first[a] < 0) d_first[a] = cyc;
                d_last[a] = cyc;
            end
            d_prev_clk[a] = c[a];
        end
        if (d_prev_busy && !busy_o) busy_fall = cyc;
        d_prev_busy = busy_o;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((busy_o || m_busy()) && n < limit) begin
            tick(0, 8'sd0, 8'sd0, 0);
            n++;
        end
        if (n >= limit) check("drain_timeout", 1, 0);
        tick(0, 8'sd0, 8'sd0, 0);
    endtask

    initial begin
        int acc_cyc;
        logic signed [7:0] rx, ry;

        clear_counts();
        d_prev_clk[0] = 0; d_prev_clk[1] = 0; d_prev_busy = 0;
        reset = 1'b1; delta_valid_i = 1'b0; delta_x_i = '0; delta_y_i = '0;

        repeat (3) tick(0, 8'sd0, 8'sd0, 1);
        check("reset_trakball", int'(trakball_o), 0);
        check("reset_ready", int'(delta_ready_o), 0);
        tick(0, 8'sd0, 8'sd0, 0);
        check("ready_after_reset", int'(delta_ready_o), 1);

        // reset held 5 cycles in the middle of a step
        tick(1, 8'sd5, -8'sd3, 0);
        repeat (6) tick(0, 8'sd0, 8'sd0, 0);
        repeat (5) begin
            tick(0, 8'sd0, 8'sd0, 1);
            check("midstep_reset_out", int'(trakball_o), 0);
            check("midstep_reset_busy", int'(busy_o), 0);
        end
        tick(0, 8'sd0, 8'sd0, 0);
        check("ready_after_midstep_reset", int'(delta_ready_o), 1);
        repeat (3) tick(0, 8'sd0, 8'sd0, 0);
        check("motion_discarded", int'(busy_o), 0);

        // +3 on X
        clear_counts();
        tick(1, 8'sd3, 8'sd0, 0);
        acc_cyc = cyc;
        drain(200);
        check("x3_rises", d_rises[0], 3);
        check("x3_up_rises", d_up_rises[0], 3);
        check("x3_y_rises", d_rises[1], 0);
        check("x3_first_rise_lat", d_first[0] - acc_cyc, 1 + SW);
        check("x3_rise_span", d_last[0] - d_first[0], 2 * STEP);
        check("x3_busy_fall", busy_fall - acc_cyc, 1 + 3 * STEP);

        // +2 then -5 accepted while the first step is HIGH
        clear_counts();
        tick(1, 8'sd2, 8'sd0, 0);
        repeat (3) tick(0, 8'sd0, 8'sd0, 0);
        check("rev_in_high", int'(trakball_o[0]), 1);
        tick(1, -8'sd5, 8'sd0, 0);
        drain(300);
        check("rev_rises", d_rises[0], 5);
        check("rev_up_rises", d_up_rises[0], 1);

        // +127 on X, then four beats of -128 on Y
        clear_counts();
        tick(1, 8'sd127, 8'sd0, 0);
        repeat (4) tick(1, 8'sd0, -8'sd128, 0);
        drain(8000);
        check("big_x_rises", d_rises[0], 127);
        check("big_x_up", d_up_rises[0], 127);
        check("big_y_rises", d_rises[1], m_rises[1]);
        check("big_y_up", d_up_rises[1], 0);

        // six beats of +127 on X drive the accumulator into saturation
        clear_counts();
        repeat (6) tick(1, 8'sd127, 8'sd0, 0);
        drain(8000);
        check("sat_x_rises", d_rises[0], m_rises[0]);

        // both axes +1 in the same beat
        clear_counts();
        tick(1, 8'sd1, 8'sd1, 0);
        drain(200);
        check("xy_same_rise", d_first[0], d_first[1]);
        check("xy_up", d_up_rises[0] + d_up_rises[1], 2);

        // +1 accepted on the very cycle X enters HIGH
        clear_counts();
        tick(1, 8'sd2, 8'sd0, 0);
        repeat (2) tick(0, 8'sd0, 8'sd0, 0);
        tick(1, 8'sd1, 8'sd0, 0);
        check("coincide_high", int'(trakball_o[0]), 1);
        drain(300);
        check("coincide_rises", d_rises[0], 3);

        // randomized deltas on both axes
        clear_counts();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rx = 8'($urandom);
                ry = 8'($urandom);
            end else begin
                rx = 8'(int'($urandom_range(0, 8)) - 4);
                ry = 8'(int'($urandom_range(0, 8)) - 4);
            end
            tick(1'($urandom_range(0, 1)), rx, ry, 0);
        end
        drain(12000);
        check("rand_x_rises", d_rises[0], m_rises[0]);
        check("rand_y_rises", d_rises[1], m_rises[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
